multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control sequencer for the 16-bit WISC datapath. It steps each instruction through fetch, decode, execute, memory and write-back phases, choosing the path from the latched instruction's opcode (`ir[15:11]`). It issues the per-phase enables to the PC, IR, register file and memory, and waits on the memory handshakes. It sits beside the instruction decoder, which it relies on for register and immediate fields, and it owns HALT handling and the memory-stall watchdog.

## Interface
- `MAX_WAIT`, default 16: maximum number of cycles either memory handshake may stay low before the watchdog trips. Legal range is 2–255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ir`  in  16  latched instruction register. Only `ir[15:11]` is used.
- `imem_done`  in  1  instruction memory has data valid this cycle.
- `dmem_done`  in  1  data memory access completes this cycle.
- `br_taken`  in  1  branch condition result from the ALU; sampled in EXEC.
- `fetch_en`  out  1  instruction memory read request.
- `ir_we`  out  1  load IR from instruction memory.
- `pc_inc`  out  1  PC <= PC+2.
- `pc_load`  out  1  PC <= branch/jump target.
- `rf_we`  out  1  register-file write.
- `link_we`  out  1  selects R7 and PC+2 as the write destination and data (JAL/JALR).
- `dmem_en`  out  1  data memory request.
- `dmem_wr`  out  1  data memory write; meaningful only when `dmem_en=1`.
- `halted`  out  1  HALT executed or watchdog tripped.
- `err`  out  1  sticky: watchdog timeout or illegal opcode seen.
- `state`  out  3  current state, for debug.
- `retired`  out  16  count of completed instructions; wraps modulo 2^16.

## Operation
- **States**: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5. Codes 6 and 7 are unused; if either occurs, the next state is FETCH.
- **Outputs**: all outputs are combinational from `state`, `ir` and the handshake inputs. The exceptions are `err`, `retired` and the wait counter, which are registered.
- **FETCH**
  - `fetch_en=1` every cycle in this state.
  - When `imem_done=1`: `ir_we=1` and `pc_inc=1` in that same cycle, and the next state is DECODE.
  - Otherwise the state holds.
- **DECODE**: lasts one cycle. The next state depends on `ir[15:11]`:
  - 00000 HALT: go to HALTED.
  - 00001 NOP: retire and go to FETCH.
  - 00010 and 00011 (unsupported): set `err`, retire as a NOP, go to FETCH.
  - Every other opcode: go to EXEC.
- **EXEC**: lasts one cycle. Actions and next state by opcode:
  - 011xx branches: `pc_load=br_taken`, then FETCH.
  - 00100 J and 00101 JR: `pc_load=1`, then FETCH.
  - 00110 JAL and 00111 JALR: `pc_load=1`, then WB with the link path.
  - 10000 ST, 10001 LD, 10011 STU: go to MEM.
  - All remaining opcodes are the ALU class (010xx, 101xx, 10010, 110xx, 111xx): go to WB.
- **MEM**
  - `dmem_en=1` every cycle in this state.
  - `dmem_wr=1` for ST and STU.
  - When `dmem_done=1`: ST goes to FETCH; LD and STU go to WB.
  - Otherwise the state holds.
- **WB**: lasts one cycle, with `rf_we=1`. `link_we=1` only for JAL/JALR. Next state is FETCH.
- **Retire**: `retired` increments by one on every transition into FETCH from any state other than FETCH. Reset does not count.
- **Watchdog**
  - `wait_cnt` is 8 bits. It clears on entry to FETCH or MEM and on any done pulse.
  - It increments on each FETCH or MEM cycle in which the relevant done input is low.
  - If `wait_cnt == MAX_WAIT-1` and done is still low, the next state is HALTED and `err` is set.
- **HALTED**
  - All enables are 0 and `halted=1`.
  - The state holds until `rst`. Done inputs are ignored.
- **Reset**
  - Takes effect on the next edge regardless of state, including mid-MEM with `dmem_en` high.
  - Resulting values: `state=FETCH`, `err=0`, `retired=0`, `wait_cnt=0`.
  - While `rst` is high, every output is forced to 0, including `fetch_en`.
  - A memory transaction outstanding at reset is abandoned; the memory owner tolerates this.

## Timing
- Minimum cycles per instruction, with done signals arriving in the first cycle:
  - NOP: 2
  - branch, J, JR: 3
  - ALU, ST, JAL, JALR: 4
  - LD, STU: 5
- Each memory wait cycle adds one cycle.
- `pc_inc` and `ir_we` are asserted for exactly one cycle per fetch, coincident with `imem_done`.
- `rf_we` is asserted for exactly one cycle per writing instruction. It is never asserted for ST, branches, J, JR, NOP or HALT.
- The first cycle after `rst` falls is FETCH with `fetch_en=1`.
- The watchdog trips on the `MAX_WAIT`th consecutive low-done cycle; `halted` is 1 on the following cycle.
- If `rst` and a done pulse arrive in the same cycle, reset wins. No `retired` increment occurs.

## Test plan
- **Reset**: hold `rst` for 2 cycles with `imem_done=1` -> all outputs 0. After release: `state=0`, `fetch_en=1`, `retired=0`.
- **NOP/ALU stream**: `ir`=0x0800 (NOP) then ADDI 0x4000, `imem_done` always 1 -> states 0,1,0,1,2,4,0; `rf_we` pulses once; `retired=2`.
- **LD with wait**: `ir`=0x8800, `dmem_done` rises on the 4th MEM cycle -> MEM lasts 4 cycles; one WB `rf_we` pulse; 8 cycles total.
- **Branch and JAL**:
  - BEQZ 0x6000 with `br_taken` high -> exactly one `pc_load` and no `pc_inc` in EXEC.
  - Same branch with `br_taken` low -> no `pc_load`.
  - JAL 0x3000 -> `pc_load`, then `rf_we` together with `link_we`.
- **HALT and watchdog**:
  - `ir`=0x0000 -> HALTED after DECODE; `halted` stays 1 for 20 cycles.
  - Separately, `MAX_WAIT=4` with `imem_done` held at 0 -> `err=1` and `halted=1` on cycle 5.
- **Reset mid-ST**: assert `rst` in the 2nd MEM cycle of ST 0x8000 -> `dmem_en` drops immediately; `retired` and `err` clear; fetch resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/write-back sequencer for the
// 16-bit WISC datapath. Issues per-phase enables, waits on memory handshakes,
// handles HALT and trips a watchdog if a memory stays busy too long.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        imem_done,
  input  logic        dmem_done,
  input  logic        br_taken,
  output logic        fetch_en,
  output logic        ir_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        rf_we,
  output logic        link_we,
  output logic        dmem_en,
  output logic        dmem_wr,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [7:0] TRIP = 8'(MAX_WAIT - 1);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;

  state_t      state_q;
  state_t      next_state;
  logic [7:0]  wait_q;
  logic [7:0]  next_wait;
  logic        err_q;
  logic        err_set;
  logic [15:0] retired_q;
  logic [4:0]  op;
  logic        is_mem_op;
  logic        is_store;
  logic        is_link;
  logic        unused_ir;

  // Only the opcode field drives sequencing; the rest belongs to the decoder.
  assign op        = ir[15:11];
  assign unused_ir = ^ir[10:0];
  assign is_mem_op = (op == OP_ST) || (op == OP_LD) || (op == OP_STU);
  assign is_store  = (op == OP_ST) || (op == OP_STU);
  assign is_link   = (op[4:1] == 4'b0011);

  // Next-state, watchdog and per-phase enables; reset masks every output.
  always_comb begin
    next_state = state_q;
    next_wait  = 8'd0;
    err_set    = 1'b0;
    fetch_en   = 1'b0;
    ir_we      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    rf_we      = 1'b0;
    link_we    = 1'b0;
    dmem_en    = 1'b0;
    dmem_wr    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_en = 1'b1;
        if (imem_done) begin
          ir_we      = 1'b1;
          pc_inc     = 1'b1;
          next_state = S_DECODE;
        end else if (wait_q == TRIP) begin
          next_state = S_HALTED;
          err_set    = 1'b1;
        end else begin
          next_wait = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          next_state = S_HALTED;
        end else if (op == OP_NOP) begin
          next_state = S_FETCH;
        end else if (op[4:1] == 4'b0001) begin
          err_set    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op[4:2] == 3'b011) begin
          pc_load    = br_taken;
          next_state = S_FETCH;
        end else if (op[4:1] == 4'b0010) begin
          pc_load    = 1'b1;
          next_state = S_FETCH;
        end else if (is_link) begin
          pc_load    = 1'b1;
          next_state = S_WB;
        end else if (is_mem_op) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        dmem_en = 1'b1;
        dmem_wr = is_store;
        if (dmem_done) begin
          next_state = (op == OP_ST) ? S_FETCH : S_WB;
        end else if (wait_q == TRIP) begin
          next_state = S_HALTED;
          err_set    = 1'b1;
        end else begin
          next_wait = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        link_we    = is_link;
        next_state = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
    if (rst) begin
      fetch_en = 1'b0;
      ir_we    = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      rf_we    = 1'b0;
      link_we  = 1'b0;
      dmem_en  = 1'b0;
      dmem_wr  = 1'b0;
      halted   = 1'b0;
    end
  end

  // Registered outputs are also held at zero while reset is asserted.
  assign state   = rst ? 3'd0  : state_q;
  assign err     = rst ? 1'b0  : err_q;
  assign retired = rst ? 16'd0 : retired_q;

  // State, wait counter, sticky error and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      err_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q <= next_state;
      wait_q  <= next_wait;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if ((next_state == S_FETCH) && (state_q != S_FETCH)) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

endmodule
